// File: rtl/cpu_wb.sv
// Writeback stage: retires one instruction at a time onto the register file write port.
// Loads wait for the data-memory response, extract/extend the addressed lane, and time out.
module cpu_wb #(
    parameter int XLEN         = 32,
    parameter int IDXW         = 5,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_rd_wen,
    input  logic [IDXW-1:0] ex_rd_idx,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      ex_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rd_wen,
    output logic [IDXW-1:0] rd_idx,
    output logic [XLEN-1:0] rd_dat,
    output logic            load_err,
    output logic            busy
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            rd_wen_q, rd_wen_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d;
    logic [XLEN-1:0] rd_dat_q, rd_dat_d;
    logic            load_err_q, load_err_d;
    logic            ld_wen_q, ld_wen_d;
    logic [IDXW-1:0] ld_idx_q, ld_idx_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_alo_q, ld_alo_d;

    logic            ld_illegal;
    logic            ld_misaligned;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] ld_ext;

    assign ex_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rd_wen   = rd_wen_q;
    assign rd_idx   = rd_idx_q;
    assign rd_dat   = rd_dat_q;
    assign load_err = load_err_q;

    assign ld_illegal    = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    assign ld_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr_lo[0])
                         || ((ex_funct3 == 3'b010) && (ex_addr_lo != 2'b00));

    assign lane_b = mem_rdata[{ld_alo_q, 3'b000} +: 8];
    assign lane_h = mem_rdata[{ld_alo_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = mem_rdata;
        case (ld_f3_q)
            3'b000:  ld_ext = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, lane_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_wen_d   = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_dat_d   = rd_dat_q;
        load_err_d = 1'b0;
        ld_wen_d   = ld_wen_q;
        ld_idx_d   = ld_idx_q;
        ld_f3_d    = ld_f3_q;
        ld_alo_d   = ld_alo_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        rd_wen_d = ex_rd_wen && (ex_rd_idx != '0);
                        rd_idx_d = ex_rd_idx;
                        rd_dat_d = ex_result;
                    end else if (ld_illegal || ld_misaligned) begin
                        load_err_d = 1'b1;
                    end else begin
                        ld_wen_d = ex_rd_wen;
                        ld_idx_d = ex_rd_idx;
                        ld_f3_d  = ex_funct3;
                        ld_alo_d = ex_addr_lo;
                        cnt_d    = 8'd0;
                        state_d  = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // A response on the final wait cycle still completes normally.
                if (mem_rvalid) begin
                    rd_wen_d = ld_wen_q && (ld_idx_q != '0);
                    rd_idx_d = ld_idx_q;
                    rd_dat_d = ld_ext;
                    cnt_d    = 8'd0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    load_err_d = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_wen_q   <= 1'b0;
            rd_idx_q   <= '0;
            rd_dat_q   <= '0;
            load_err_q <= 1'b0;
            ld_wen_q   <= 1'b0;
            ld_idx_q   <= '0;
            ld_f3_q    <= 3'b000;
            ld_alo_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_wen_q   <= rd_wen_d;
            rd_idx_q   <= rd_idx_d;
            rd_dat_q   <= rd_dat_d;
            load_err_q <= load_err_d;
            ld_wen_q   <= ld_wen_d;
            ld_idx_q   <= ld_idx_d;
            ld_f3_q    <= ld_f3_d;
            ld_alo_q   <= ld_alo_d;
        end
    end
endmodule

// File: doc/cpu_wb.md
# cpu_wb

Writeback stage of the EmmmCS core: accepts one retiring instruction at a time from execute and drives the general register file write port (rd_wen/rd_idx/rd_dat). For loads, it waits for the data-memory read response, extracts and extends the addressed byte/halfword/word, and bounds the wait with a timeout. Sits between the execute/memory stage (upstream) and the register file (downstream).

## Interface
- XLEN, 32, data width (`CPU_XLEN`)
- IDXW, 5, register index width (`CPU_GREGIDX_WIDTH`)
- LOAD_TIMEOUT, 255, max cycles in WAIT_MEM before abort (≥2, counter 8 bits)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  wb can accept (combinational: state==IDLE)
- ex_rd_wen  in  1  instruction writes rd
- ex_rd_idx  in  IDXW  destination register
- ex_result  in  XLEN  ALU/CSR result (non-load)
- ex_is_load  in  1  instruction is a load
- ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ex_addr_lo  in  2  load address bits [1:0]
- mem_rvalid  in  1  read data valid (one-cycle pulse)
- mem_rdata  in  XLEN  aligned 32-bit word containing the load target
- rd_wen  out  1  regfile write enable (registered)
- rd_idx  out  IDXW  regfile write index (registered)
- rd_dat  out  XLEN  regfile write data (registered)
- load_err  out  1  one-cycle pulse: misaligned/illegal load or timeout
- busy  out  1  state!=IDLE

## Operation
- States: IDLE, WAIT_MEM. Accept = ex_valid && ex_ready.
- IDLE, accept, !ex_is_load: next cycle rd_wen = ex_rd_wen && (ex_rd_idx!=0), rd_idx = ex_rd_idx, rd_dat = ex_result; stay IDLE.
- IDLE, accept, load, legal and aligned: latch rd_idx/rd_wen request/funct3/addr_lo; → WAIT_MEM, counter=0.
- Alignment: LH/LHU need addr_lo[0]==0; LW needs addr_lo==00. funct3 ∈ {011,110,111} illegal. Misaligned or illegal: load_err pulses next cycle, no write, stay IDLE.
- WAIT_MEM, mem_rvalid: extract byte at mem_rdata[8*addr_lo +: 8] or halfword at mem_rdata[16*addr_lo[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Next cycle rd_wen (suppressed if rd_idx==0 or request had rd_wen=0), rd_dat = extracted; → IDLE.
- WAIT_MEM, no rvalid: counter+1; when counter==LOAD_TIMEOUT-1 and no rvalid, → IDLE, load_err pulses next cycle, no write. rvalid on that same cycle wins (normal completion).
- mem_rvalid in IDLE ignored (no write, no error).
- rd_wen, load_err high exactly one cycle per event; rd_idx/rd_dat hold last value otherwise.

## Timing
- Reset (any state, including WAIT_MEM): state=IDLE, counter=0, rd_wen=0, rd_idx=0, rd_dat=0, load_err=0, busy=0; pending load discarded, later rvalid ignored.
- Non-load latency: 1 cycle accept→rd_wen. Throughput 1/cycle back-to-back.
- Load latency: rvalid cycle +1 → rd_wen. ex_ready low from cycle after load accept until cycle after rvalid/timeout.
- ex_ready is combinational from state only; no dependence on ex_valid.
- rd_wen never asserted with rd_idx==0.

## Test plan
- ALU write: accept rd=5, result 0xDEADBEEF → next cycle rd_wen=1, rd_idx=5, rd_dat=0xDEADBEEF; back-to-back second instr rd=6 writes the following cycle.
- x0 discard: accept rd=0, result 0x1234 → rd_wen stays 0.
- LB/LBU: load rd=3, addr_lo=3, rvalid after 4 cycles with mem_rdata=0x80112233 → rd_dat=0xFFFFFF80 (LB), 0x00000080 (LBU); ex_ready low throughout wait.
- LH/LW: LH addr_lo=2, rdata=0x9ABC1234 → 0xFFFF9ABC; LW addr_lo=1 → load_err pulse, no write, ex_ready stays 1.
- Timeout: LOAD_TIMEOUT=8, load with no rvalid → load_err one cycle after 8th wait cycle, rd_wen=0, back to IDLE; late rvalid ignored.
- Reset mid-load: reset_n low in WAIT_MEM → all outputs 0, busy=0; subsequent rvalid produces no write.
